// File: rtl/seven_segment_mux_driver.sv
// seven_segment_mux_driver
//
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// sharing one cathode bus. Each digit owns a slot of DIGIT_PERIOD_CYCLES
// clocks. The first BLANK_CYCLES of every slot are fully dark so the previous
// digit's segments cannot ghost onto the next one. Display data is
// double-buffered: load_i fills a pending buffer, and the pending buffer is
// promoted to the active buffer only at the end of a full scan. The visible
// value therefore never tears mid-frame.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   digits_i      4 bits per digit, digit i = digits_i[4i+3:4i] (MSD on top)
//   dots_i        per-digit decimal point (1 = lit)
//   digit_en_i    per-digit enable (0 = digit dark)
//   lz_blank_i    1 = suppress leading zeros
//   load_i        1-cycle strobe, captures the four inputs above
//   anodes_o      active-low digit selects
//   cathodes_o    active-low segments, [7:0] = CA,CB,CC,CD,CE,CF,CG,DP
//   frame_done_o  1-cycle pulse after the last cycle of each full scan
//
// Handshake: load_i is a plain strobe with no back-pressure. Every cycle in
// which it is high overwrites the pending buffer, so the last load in a frame
// wins. A load in the frame-boundary cycle also goes straight to the active
// buffer.

module seven_segment_mux_driver #(
  parameter int NUM_DIGITS          = 4,
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int BLANK_CYCLES        = 16,
  parameter bit HEX_EN              = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dots_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_blank_i,
  input  logic                    load_i,
  output logic [NUM_DIGITS-1:0]   anodes_o,
  output logic [7:0]              cathodes_o,
  output logic                    frame_done_o
);

  // Parameter legality: any violation stops elaboration.
  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
      $error("NUM_DIGITS must be in 1..16");
    end
    if (DIGIT_PERIOD_CYCLES < 2) begin : g_bad_period
      $error("DIGIT_PERIOD_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIGIT_PERIOD_CYCLES) begin : g_bad_blank
      $error("BLANK_CYCLES must be in 0..DIGIT_PERIOD_CYCLES-1");
    end
  endgenerate

  localparam int CNT_W = $clog2(DIGIT_PERIOD_CYCLES);
  // A single digit still needs a 1-bit index to stay a legal vector.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dots;
    logic [NUM_DIGITS-1:0]   en;
    logic                    lz;
  } disp_buf_t;

  // Segment patterns CA..CG, active low.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] seg;
    seg = 7'h7F;
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = HEX_EN ? 7'b0001000 : 7'h7F;
      4'hB: seg = HEX_EN ? 7'b1100000 : 7'h7F;
      4'hC: seg = HEX_EN ? 7'b0110001 : 7'h7F;
      4'hD: seg = HEX_EN ? 7'b1000010 : 7'h7F;
      4'hE: seg = HEX_EN ? 7'b0110000 : 7'h7F;
      4'hF: seg = HEX_EN ? 7'b0111000 : 7'h7F;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  disp_buf_t             pend_q, act_q, live_buf;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]            cathodes_q, cathodes_d;
  logic                  frame_done_q;
  logic                  frame_end;

  assign live_buf  = '{digits: digits_i, dots: dots_i, en: digit_en_i, lz: lz_blank_i};
  assign frame_end = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero suppression over the active buffer. Scanning from the top
  // digit down, zero_above stays set while every higher digit is 0 or off.
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_above;
  logic                  val_zero;

  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    val_zero   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      val_zero   = (act_q.digits[4*i +: 4] == 4'h0);
      supp[i]    = act_q.lz && val_zero && zero_above && (i != 0);
      zero_above = zero_above && (val_zero || !act_q.en[i]);
    end
  end

  // Output image for the current (idx, cnt). It is registered below, so the
  // pins show it one cycle later.
  logic [3:0] cur_val;
  logic       cur_dot;
  logic       cur_lit;

  always_comb begin
    cur_val    = act_q.digits[4*int'(idx_q) +: 4];
    cur_dot    = act_q.dots[idx_q];
    // A suppressed digit keeps its anode on only to show a set dot.
    cur_lit    = act_q.en[idx_q] && (!supp[idx_q] || cur_dot);
    anodes_d   = '1;
    cathodes_d = 8'hFF;
    if (int'(cnt_q) >= BLANK_CYCLES && cur_lit) begin
      anodes_d[idx_q] = 1'b0;
      cathodes_d      = {(supp[idx_q] ? 7'h7F : decode(cur_val)), ~cur_dot};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      anodes_q     <= '1;
      cathodes_q   <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
      frame_done_q <= frame_end;
      if (load_i) begin
        pend_q <= live_buf;
      end
      // A load in the boundary cycle bypasses pending so it is not lost.
      if (frame_end) begin
        act_q <= load_i ? live_buf : pend_q;
      end
    end
  end

  assign anodes_o     = anodes_q;
  assign cathodes_o   = cathodes_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Bench for seven_segment_mux_driver: two instances (HEX_EN=1 and 0) share
// the stimulus. A frame-position model predicts every output cycle.

module tb_seven_segment_mux_driver;

  localparam int N     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * P;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4*N-1:0] digits;
  logic [N-1:0]   dots, digit_en;
  logic           lz_blank, load;

  logic [N-1:0] an_h, an_n;
  logic [7:0]   cat_h, cat_n;
  logic         fd_h, fd_n;

  seven_segment_mux_driver #(
    .NUM_DIGITS(N), .DIGIT_PERIOD_CYCLES(P), .BLANK_CYCLES(B), .HEX_EN(1'b1)
  ) dut_hex (
    .clk(clk), .rst(rst), .digits_i(digits), .dots_i(dots),
    .digit_en_i(digit_en), .lz_blank_i(lz_blank), .load_i(load),
    .anodes_o(an_h), .cathodes_o(cat_h), .frame_done_o(fd_h)
  );

  seven_segment_mux_driver #(
    .NUM_DIGITS(N), .DIGIT_PERIOD_CYCLES(P), .BLANK_CYCLES(B), .HEX_EN(1'b0)
  ) dut_dec (
    .clk(clk), .rst(rst), .digits_i(digits), .dots_i(dots),
    .digit_en_i(digit_en), .lz_blank_i(lz_blank), .load_i(load),
    .anodes_o(an_n), .cathodes_o(cat_n), .frame_done_o(fd_n)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int         k = 0;  // cycles since reset release = position in the scan
  logic [4*N-1:0] p_dig = '0, a_dig = '0;
  logic [N-1:0]   p_dot = '0, a_dot = '0, p_en = '0, a_en = '0;
  logic           p_lz = 1'b0, a_lz = 1'b0;

  logic [N-1:0] ex_an_h = '1, ex_an_n = '1;
  logic [7:0]   ex_cat_h = 8'hFF, ex_cat_n = 8'hFF;
  logic         ex_fd = 1'b0;

  // What the display must show for digit position d, cycle c within the slot.
  function automatic logic [N+7:0] model_out(input int d, input int c, input bit hex);
    logic [N-1:0] an;
    logic [7:0]   cat;
    logic [3:0]   v;
    logic [6:0]   seg;
    bit           zero_above, sup;
    an  = '1;
    cat = 8'hFF;
    if (c >= B) begin
      v = a_dig[4*d +: 4];
      zero_above = 1'b1;
      for (int j = d + 1; j < N; j++)
        if (a_dig[4*j +: 4] != 4'h0 && a_en[j]) zero_above = 1'b0;
      sup = a_lz && (v == 4'h0) && zero_above && (d != 0);
      if (a_en[d] && (!sup || a_dot[d])) begin
        an[d] = 1'b0;
        if (sup) seg = 7'h7F;
        else if (v < 10 || hex) seg = seg_tab[v];
        else seg = 7'h7F;
        cat = {seg, ~a_dot[d]};
      end
    end
    return {an, cat};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
      p_dig <= '0; p_dot <= '0; p_en <= '0; p_lz <= 1'b0;
      a_dig <= '0; a_dot <= '0; a_en <= '0; a_lz <= 1'b0;
      ex_an_h <= '1; ex_an_n <= '1; ex_cat_h <= 8'hFF; ex_cat_n <= 8'hFF;
      ex_fd <= 1'b0;
    end else begin
      {ex_an_h, ex_cat_h} <= model_out((k / P) % N, k % P, 1'b1);
      {ex_an_n, ex_cat_n} <= model_out((k / P) % N, k % P, 1'b0);
      ex_fd <= (k % FRAME == FRAME - 1);
      if (load) begin
        p_dig <= digits; p_dot <= dots; p_en <= digit_en; p_lz <= lz_blank;
      end
      if (k % FRAME == FRAME - 1) begin
        a_dig <= load ? digits   : p_dig;
        a_dot <= load ? dots     : p_dot;
        a_en  <= load ? digit_en : p_en;
        a_lz  <= load ? lz_blank : p_lz;
      end
      k <= k + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("anodes_hex",   16'(an_h),  16'(ex_an_h));
    chk("cathodes_hex", 16'(cat_h), 16'(ex_cat_h));
    chk("frame_done_hex", 16'(fd_h), 16'(ex_fd));
    chk("anodes_dec",   16'(an_n),  16'(ex_an_n));
    chk("cathodes_dec", 16'(cat_n), 16'(ex_cat_n));
    chk("frame_done_dec", 16'(fd_n), 16'(ex_fd));
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds load for exactly one rising edge.
  task automatic do_load(input logic [15:0] dg, input logic [3:0] dt,
                         input logic [3:0] en, input logic lz);
    digits = dg; dots = dt; digit_en = en; lz_blank = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance to the next negedge where the pins show digit slot s, cycle c.
  task automatic wait_show(input int s, input int c, input string nm);
    bit found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (k > 0 && ((k - 1) / P) % N == s && (k - 1) % P == c) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_%s: slot position not reached", nm);
    end
  endtask

  task automatic pin(input string nm, input logic [3:0] an, input logic [7:0] cat);
    chk({nm, "_an_hex"},  16'(an_h),  16'(an));
    chk({nm, "_cat_hex"}, 16'(cat_h), 16'(cat));
  endtask

  logic [15:0] rnd_dig;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; load = 1'b0; digits = '0; dots = '0; digit_en = '0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an",  16'(an_h),  16'h000F);
    chk("reset_cat", 16'(cat_h), 16'h00FF);
    chk("reset_fd",  16'(fd_h),  16'h0000);
    rst = 1'b0;
    repeat (40) @(negedge clk);  // dark display, frame_done every 32 cycles

    // Plain decimal digits with one dot.
    do_load(16'h1234, 4'b0100, 4'hF, 1'b0);
    wait_show(0, 1, "s0c1"); pin("blank_gap", 4'b1111, 8'hFF);
    wait_show(0, 2, "s0c2"); pin("dig4",      4'b1110, 8'b10011001);
    wait_show(2, 5, "s2c5"); pin("dig2_dp",   4'b1011, 8'b00100100);

    // Mid-frame load: slot 3 of this frame still shows the old '1'.
    do_load(16'hABCD, 4'b0000, 4'hF, 1'b0);
    wait_show(3, 2, "old3"); pin("midframe_old", 4'b0111, 8'b10011111);
    wait_show(3, 2, "hexA"); pin("hex_A", 4'b0111, 8'b00010001);
    chk("dec_A_an",  16'(an_n),  16'h0007);
    chk("dec_A_cat", 16'(cat_n), 16'h00FF);

    // Leading-zero blanking.
    do_load(16'h0050, 4'b1000, 4'hF, 1'b1);
    wait_show(0, 2, "lz0"); pin("lz_d0", 4'b1110, 8'b00000011);
    wait_show(1, 2, "lz1"); pin("lz_d1", 4'b1101, 8'b01001001);
    wait_show(2, 2, "lz2"); pin("lz_d2", 4'b1111, 8'hFF);
    wait_show(3, 2, "lz3"); pin("lz_d3", 4'b0111, 8'b11111110);
    do_load(16'h0050, 4'b1000, 4'hF, 1'b0);
    wait_show(2, 2, "nolz2"); pin("nolz_d2", 4'b1011, 8'b00000011);
    wait_show(3, 2, "nolz3"); pin("nolz_d3", 4'b0111, 8'b00000010);

    // Load exactly in the frame-boundary cycle.
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
        if (k % FRAME == FRAME - 1) hit = 1'b1;
        else @(negedge clk);
      end
      if (!hit) begin
        total++; bad++;
        $display("FAIL boundary_wait: boundary not reached");
      end
    end
    do_load(16'h9876, 4'b0000, 4'hF, 1'b0);
    wait_show(0, 2, "bnd"); pin("boundary_load", 4'b1110, 8'b01000001);

    // Two loads in one frame: the second wins.
    do_load(16'h1111, 4'b0000, 4'hF, 1'b0);
    repeat (5) @(negedge clk);
    do_load(16'h0002, 4'b0001, 4'h1, 1'b0);
    wait_show(0, 2, "two0"); pin("last_load_d0", 4'b1110, 8'b00100100);
    wait_show(1, 2, "two1"); pin("last_load_d1", 4'b1111, 8'hFF);

    // Reset in slot 2 of a lit display.
    do_load(16'h5555, 4'b0000, 4'hF, 1'b0);
    wait_show(0, 2, "pre_rst");
    wait_show(2, 4, "rst_slot"); pin("pre_reset", 4'b1011, 8'b01001001);
    #2 rst = 1'b1;
    #1 pin("async_reset", 4'b1111, 8'hFF);
    chk("async_reset_fd", 16'(fd_h), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (70) @(negedge clk);  // stays dark: buffers were cleared

    // Randomised loads at random points of the scan.
    repeat (60) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      for (int d = 0; d < N; d++)
        rnd_dig[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      do_load(rnd_dig, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
    end
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
